idma_desc64_ar_arb: RTL and testbench

- Shares one AXI AR channel between NumCh independent desc64 descriptor-fetch channels.
- Each channel presents a fetch address through a valid/ready handshake.
- The block picks a winner round-robin, registers the address and drives a stable AR beat with ID equal to the channel index.
- It tracks outstanding descriptor reads per channel by watching R-last beats, and blocks a channel once its limit is reached.

---
 rtl/idma_desc64_ar_arb.sv | 161 ++++++++++++++++
 tb/tb_idma_desc64_ar_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_desc64_ar_arb.sv
// Round-robin arbiter sharing one AXI AR channel between NumCh desc64 fetch channels,
// with per-channel outstanding-read limiting. Define IDMA_DESC64_AR_ARB_PRIO_EN to add prio_i.
module idma_desc64_ar_arb #(
  parameter int unsigned NumCh          = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned IdWidth        = 2,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned DescSize       = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
`ifdef IDMA_DESC64_AR_ARB_PRIO_EN
  input  logic [NumCh-1:0]           prio_i,
`endif
  input  logic [NumCh*AddrWidth-1:0] req_addr_i,
  input  logic [NumCh-1:0]           req_valid_i,
  output logic [NumCh-1:0]           req_ready_o,
  output logic [AddrWidth-1:0]       ar_addr_o,
  output logic [IdWidth-1:0]         ar_id_o,
  output logic [7:0]                 ar_len_o,
  output logic [2:0]                 ar_size_o,
  output logic                       ar_valid_o,
  input  logic                       ar_ready_i,
  input  logic [IdWidth-1:0]         r_id_i,
  input  logic                       r_last_i,
  input  logic                       r_valid_i,
  input  logic                       r_ready_i,
  output logic [NumCh*3-1:0]         outstanding_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned SizeLog   = ($clog2(BeatBytes) < $clog2(DescSize)) ?
                                      $clog2(BeatBytes) : $clog2(DescSize);
  localparam logic [7:0]  ArLen     = 8'(DescSize / BeatBytes - 1);
  localparam logic [2:0]  ArSize    = 3'(SizeLog);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                     state_q, state_d;
  logic [IdWidth-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IdWidth-1:0]         id_q, id_d;
  logic [AddrWidth-1:0]       addr_q, addr_d;
  logic [NumCh-1:0][2:0]      cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic [NumCh-1:0]           elig, cand, inc, dec;
  logic                       win_vld, ar_hs, r_last_hs;
  logic [IdWidth-1:0]         win_id;

  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      elig[c] = req_valid_i[c] && (cnt_q[c] < 3'(MaxOutstanding));
    end
  end

`ifdef IDMA_DESC64_AR_ARB_PRIO_EN
  assign cand = (|(elig & prio_i)) ? (elig & prio_i) : elig;
`else
  assign cand = elig;
`endif

  // Rotating scan: first pass from rr_ptr upward, second pass wraps to the low channels.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int c = 0; c < NumCh; c++) begin
      if (!win_vld && cand[c] && (c >= int'(rr_ptr_q))) begin
        win_vld = 1'b1;
        win_id  = IdWidth'(c);
      end
    end
    for (int c = 0; c < NumCh; c++) begin
      if (!win_vld && cand[c]) begin
        win_vld = 1'b1;
        win_id  = IdWidth'(c);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    req_ready_o = '0;
    ar_hs       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld && !rst_i) begin
          for (int c = 0; c < NumCh; c++) begin
            if (IdWidth'(c) == win_id) begin
              req_ready_o[c] = 1'b1;
              addr_d         = req_addr_i[c*AddrWidth +: AddrWidth];
            end
          end
          id_d    = win_id;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ar_ready_i) begin
          ar_hs    = 1'b1;
          rr_ptr_d = (id_q == IdWidth'(NumCh - 1)) ? '0 : id_q + IdWidth'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign r_last_hs = r_valid_i && r_ready_i && r_last_i && (32'(r_id_i) < NumCh);

  // A same-cycle issue and completion on one channel cancel out.
  always_comb begin
    inc   = '0;
    dec   = '0;
    cnt_d = cnt_q;
    err_d = err_q;
    for (int c = 0; c < NumCh; c++) begin
      inc[c] = ar_hs && (id_q == IdWidth'(c));
      dec[c] = r_last_hs && (r_id_i == IdWidth'(c));
      if (inc[c] && !dec[c]) begin
        cnt_d[c] = cnt_q[c] + 3'd1;
      end else if (dec[c] && !inc[c]) begin
        if (cnt_q[c] == 3'd0) err_d = 1'b1;
        else                  cnt_d[c] = cnt_q[c] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign ar_valid_o    = (state_q == SEND);
  assign ar_addr_o     = addr_q;
  assign ar_id_o       = id_q;
  assign ar_len_o      = ArLen;
  assign ar_size_o     = ArSize;
  assign outstanding_o = cnt_q;
  assign busy_o        = (state_q == SEND) || (|cnt_q);
  assign err_o         = err_q;

endmodule

// File: tb/tb_idma_desc64_ar_arb.sv
// Scoreboard bench for idma_desc64_ar_arb: a transaction-level model predicts grants,
// AR beats, outstanding counts and err; a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_idma_desc64_ar_arb;
  localparam int N    = 4;
  localparam int AW   = 64;
  localparam int IW   = 2;
  localparam int MAXO = 2;
`ifdef IDMA_DESC64_AR_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [AW-1:0]   ar_addr_o;
  logic [IW-1:0]   ar_id_o;
  logic [7:0]      ar_len_o;
  logic [2:0]      ar_size_o;
  logic            ar_valid_o;
  logic            ar_ready_i = 1'b0;
  logic [IW-1:0]   r_id_i = '0;
  logic            r_last_i = 1'b0;
  logic            r_valid_i = 1'b0;
  logic            r_ready_i = 1'b0;
  logic [N*3-1:0]  outstanding_o;
  logic            busy_o;
  logic            err_o;
`ifdef IDMA_DESC64_AR_ARB_PRIO_EN
  logic [N-1:0]    prio_i = '0;
`endif

  always #5 clk = ~clk;

  idma_desc64_ar_arb #(
    .NumCh(N), .AddrWidth(AW), .IdWidth(IW), .DataWidth(64), .DescSize(32), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
`ifdef IDMA_DESC64_AR_ARB_PRIO_EN
    .prio_i(prio_i),
`endif
    .req_addr_i(req_addr_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_id_i(r_id_i), .r_last_i(r_last_i), .r_valid_i(r_valid_i), .r_ready_i(r_ready_i),
    .outstanding_o(outstanding_o), .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } ar_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  ar_t         exp_q[$];
  int          hs_log[$];
  logic [63:0] nxt_addr[N];
  logic [N-1:0] exp_rdy = '0;

  // Model state: m_* is the current cycle, n_* what the coming clock edge produces.
  int m_cnt[N];
  int n_cnt[N];
  int m_rr = 0, n_rr = 0, m_id = 0, n_id = 0;
  bit m_send = 0, n_send = 0, m_err = 0, n_err = 0, clr_q = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst_v, input logic [N-1:0] vld, input bit ardy,
                      input bit rv, input bit rr, input int rid, input bit rl,
                      input logic [N-1:0] pr);
    logic [N-1:0] elig, cand;
    ar_t e;
    @(posedge clk);
    m_cnt = n_cnt; m_rr = n_rr; m_id = n_id; m_send = n_send; m_err = n_err;
    if (clr_q) begin
      exp_q.delete();
      clr_q = 0;
    end
    #1;
    rst_i = rst_v; req_valid_i = vld; ar_ready_i = ardy;
    r_valid_i = rv; r_ready_i = rr; r_last_i = rl; r_id_i = IW'(rid);
    for (int c = 0; c < N; c++) req_addr_i[c*AW +: AW] = nxt_addr[c];
`ifdef IDMA_DESC64_AR_ARB_PRIO_EN
    prio_i = pr;
`endif
    exp_rdy = '0;
    if (rst_v) begin
      for (int c = 0; c < N; c++) n_cnt[c] = 0;
      n_rr = 0; n_id = 0; n_send = 0; n_err = 0; clr_q = 1;
    end else begin
      if (!m_send) begin
        for (int c = 0; c < N; c++) elig[c] = vld[c] && (m_cnt[c] < MAXO);
        cand = elig;
        if (PRIO && ((elig & pr) != '0)) cand = elig & pr;
        for (int i = 0; i < N; i++) begin
          if (cand[(m_rr + i) % N]) begin
            exp_rdy[(m_rr + i) % N] = 1'b1;
            e.addr = nxt_addr[(m_rr + i) % N];
            e.id   = IW'((m_rr + i) % N);
            exp_q.push_back(e);
            n_send = 1;
            n_id   = (m_rr + i) % N;
            break;
          end
        end
      end else if (ardy) begin
        n_cnt[m_id] = m_cnt[m_id] + 1;
        n_rr        = (m_id + 1) % N;
        n_send      = 0;
      end
      if (rv && rr && rl && rid < N) begin
        if (m_send && ardy && m_id == rid) n_cnt[rid] = m_cnt[rid];
        else if (m_cnt[rid] == 0)          n_err = 1;
        else                               n_cnt[rid] = m_cnt[rid] - 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    step(1, '0, 0, 0, 0, 0, 0, '0);
    step(1, '0, 0, 0, 0, 0, 0, '0);
  endtask

  // Keeps channels requesting with AR always accepted and returns each read's R-last next cycle.
  task automatic run_ret(input logic [N-1:0] vld, input logic [N-1:0] pr, input int cycles);
    int ret;
    int rid;
    bit rv;
    ret = 0;
    hs_log.delete();
    for (int k = 0; k < cycles; k++) begin
      rv = 0; rid = 0;
      if (ret < hs_log.size()) begin
        rid = hs_log[ret];
        ret++;
        rv = 1;
      end
      step(0, vld, 1, rv, rv, rid, rv, pr);
    end
  endtask

  // Monitor: compares every output against the model and pops the scoreboard on AR handshakes.
  initial begin
    int any;
    forever begin
      @(negedge clk);
      chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
      any = 0;
      for (int c = 0; c < N; c++) begin
        chk($sformatf("outstanding[%0d]", c), 64'(outstanding_o[c*3 +: 3]), 64'(m_cnt[c]));
        if (m_cnt[c] != 0) any = 1;
      end
      chk("err", 64'(err_o), 64'(m_err));
      chk("busy", 64'(busy_o), 64'(m_send || any != 0));
      if (ar_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ar_unexpected: got AR id %0d addr 0x%0h, expected none", ar_id_o, ar_addr_o);
        end else begin
          chk("ar_addr", ar_addr_o, exp_q[0].addr);
          chk("ar_id", 64'(ar_id_o), 64'(exp_q[0].id));
          chk("ar_len", 64'(ar_len_o), 64'd3);
          chk("ar_size", 64'(ar_size_o), 64'd3);
          if (ar_ready_i) begin
            hs_log.push_back(int'(ar_id_o));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] v;
    int rid, s;
    bit rl;
    for (int c = 0; c < N; c++) begin
      nxt_addr[c] = 64'h100 * (c + 1);
      m_cnt[c] = 0;
      n_cnt[c] = 0;
    end

    // Reset state
    do_reset();
    idle(1);
    #1;
    chk("rst_ar_valid", 64'(ar_valid_o), 64'd0);
    chk("rst_ar_addr", ar_addr_o, 64'd0);
    chk("rst_ar_id", 64'(ar_id_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);

    // Single request on channel 1
    nxt_addr[1] = 64'h1000;
    step(0, 4'b0010, 0, 0, 0, 0, 0, '0);
    #1 chk("single_req_ready", 64'(req_ready_o), 64'b0010);
    step(0, 4'b0000, 0, 0, 0, 0, 0, '0);
    #1;
    chk("single_ar_valid", 64'(ar_valid_o), 64'd1);
    chk("single_ar_addr", ar_addr_o, 64'h1000);
    chk("single_ar_id", 64'(ar_id_o), 64'd1);
    chk("single_ar_len", 64'(ar_len_o), 64'd3);
    chk("single_ar_size", 64'(ar_size_o), 64'd3);
    step(0, 4'b0000, 1, 0, 0, 0, 0, '0);
    idle(1);
    #1 chk("single_outstanding1", 64'(outstanding_o[5:3]), 64'd1);

    // Fairness
    do_reset();
    run_ret(4'b1111, '0, 18);
    chk("fair_grants_seen", 64'(hs_log.size() >= 8), 64'd1);
    if (hs_log.size() >= 8) begin
      int tally[N];
      for (int c = 0; c < N; c++) tally[c] = 0;
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("fair_order[%0d]", i), 64'(hs_log[i]), 64'(i % 4));
        if (hs_log[i] >= 0 && hs_log[i] < N) tally[hs_log[i]]++;
      end
      for (int c = 0; c < N; c++) chk($sformatf("fair_share[%0d]", c), 64'(tally[c]), 64'd2);
    end

    // Backpressure on channel 0
    do_reset();
    nxt_addr[0] = 64'hABCD_0000;
    step(0, 4'b0001, 0, 0, 0, 0, 0, '0);
    hs_log.delete();
    for (int i = 0; i < 5; i++) begin
      step(0, 4'b1111, 0, 0, 0, 0, 0, '0);
      #1;
      chk("bp_addr", ar_addr_o, 64'hABCD_0000);
      chk("bp_id", 64'(ar_id_o), 64'd0);
      chk("bp_req_ready", 64'(req_ready_o), 64'd0);
    end
    step(0, 4'b0000, 1, 0, 0, 0, 0, '0);
    step(0, 4'b0000, 1, 0, 0, 0, 0, '0);
    step(0, 4'b0000, 1, 0, 0, 0, 0, '0);
    chk("bp_handshakes", 64'(hs_log.size()), 64'd1);

    // Outstanding limit on channel 2
    do_reset();
    nxt_addr[2] = 64'h2200; nxt_addr[3] = 64'h3300;
    hs_log.delete();
    for (int i = 0; i < 4; i++) step(0, 4'b0100, 1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, 4'b1100, 1, 0, 0, 0, 0, '0);
    step(0, 4'b0100, 1, 1, 1, 2, 1, '0);
    step(0, 4'b0100, 1, 0, 0, 0, 0, '0);
    #1 chk("limit_regrant", 64'(req_ready_o), 64'b0100);
    chk("limit_grants_seen", 64'(hs_log.size() >= 4), 64'd1);
    if (hs_log.size() >= 4) begin
      chk("limit_g0", 64'(hs_log[0]), 64'd2);
      chk("limit_g1", 64'(hs_log[1]), 64'd2);
      chk("limit_g2", 64'(hs_log[2]), 64'd3);
      chk("limit_g3", 64'(hs_log[3]), 64'd3);
    end

    // Simultaneous issue/complete, then completion with nothing outstanding
    do_reset();
    step(0, 4'b0001, 1, 0, 0, 0, 0, '0);
    step(0, 4'b0001, 1, 0, 0, 0, 0, '0);
    step(0, 4'b0001, 1, 0, 0, 0, 0, '0);
    step(0, 4'b0000, 1, 1, 1, 0, 1, '0);
    idle(1);
    #1 chk("simul_cnt0", 64'(outstanding_o[2:0]), 64'd1);
    step(0, 4'b0000, 0, 1, 1, 3, 1, '0);
    idle(1);
    #1;
    chk("simul_err", 64'(err_o), 64'd1);
    chk("simul_cnt3", 64'(outstanding_o[11:9]), 64'd0);

    // Reset while an AR is pending
    do_reset();
    nxt_addr[1] = 64'h5150;
    step(0, 4'b0010, 0, 0, 0, 0, 0, '0);
    step(0, 4'b0000, 0, 0, 0, 0, 0, '0);
    #1 chk("rstsend_valid_before", 64'(ar_valid_o), 64'd1);
    step(1, 4'b0000, 0, 0, 0, 0, 0, '0);
    step(0, 4'b0000, 0, 0, 0, 0, 0, '0);
    #1;
    chk("rstsend_valid_after", 64'(ar_valid_o), 64'd0);
    chk("rstsend_addr_after", ar_addr_o, 64'd0);

    if (PRIO) begin
      do_reset();
      run_ret(4'b1001, 4'b1000, 9);
      chk("prio_grants_seen", 64'(hs_log.size() >= 4), 64'd1);
      for (int i = 0; i < 4 && i < hs_log.size(); i++)
        chk($sformatf("prio_hi[%0d]", i), 64'(hs_log[i]), 64'd3);
      do_reset();
      run_ret(4'b1001, 4'b0000, 9);
      chk("prio_off_grants_seen", 64'(hs_log.size() >= 4), 64'd1);
      for (int i = 0; i < 4 && i < hs_log.size(); i++)
        chk($sformatf("prio_off[%0d]", i), 64'(hs_log[i]), (i % 2 == 0) ? 64'd0 : 64'd3);
    end

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(3) == 0) nxt_addr[c] = {$urandom, $urandom};
      v   = N'($urandom);
      rid = int'($urandom_range(N - 1));
      rl  = 0;
      if ($urandom_range(2) == 0) begin
        s = int'($urandom_range(N - 1));
        for (int i = 0; i < N; i++) begin
          if (!rl && n_cnt[(s + i) % N] > 0) begin
            rid = (s + i) % N;
            rl  = 1;
          end
        end
      end
      step(0, v, $urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
           rid, rl, N'($urandom));
    end

    // Drain outstanding ARs
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 0, 0, 0, '0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
